alu_issue_ctrl: RTL and testbench

- Sequencer that sits between instruction decode and the 32-bit gate-level ALU (ADD/SUB/XOR/SLT/MUL).
- Accepts one R-type operation at a time over a valid/ready handshake and decodes the funct field into the 3-bit ALU control.
- Holds operands and control stable for a per-op settle window, because the ALU is ripple/gate-delay based and MUL settles much later than the other ops.
- Captures the ALU result and flags into registers and presents them downstream over a second valid/ready handshake.

---
 rtl/alu_issue_ctrl_if.sv | 40 ++++
 rtl/alu_issue_ctrl.sv | 132 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the decode-side request, ALU drive/return and downstream result
// handshake signals for alu_issue_ctrl.
interface alu_issue_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_funct;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_out;
  logic        alu_zero;
  logic        alu_overflow;
  logic        alu_cout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_overflow;
  logic        out_cout;
  logic        out_illegal;
  logic [15:0] op_count;

  modport slave (
    input  in_valid, in_funct, in_a, in_b,
    input  alu_out, alu_zero, alu_overflow, alu_cout,
    input  out_ready,
    output in_ready, alu_a, alu_b, alu_ctrl,
    output out_valid, out_result, out_zero, out_overflow, out_cout, out_illegal, op_count
  );

  modport master (
    output in_valid, in_funct, in_a, in_b,
    output alu_out, alu_zero, alu_overflow, alu_cout,
    output out_ready,
    input  in_ready, alu_a, alu_b, alu_ctrl,
    input  out_valid, out_result, out_zero, out_overflow, out_cout, out_illegal, op_count
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one R-type op to a gate-delay ALU, holds its inputs for a per-op
// settle window, then captures and presents the result downstream.
module alu_issue_ctrl #(
  parameter int FAST_CYCLES = 4,
  parameter int MUL_CYCLES  = 20,
  parameter int CNT_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_issue_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_e;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        cout;
    logic        illegal;
  } rsp_t;

  localparam logic [2:0]       CTRL_MUL = 3'b100;
  localparam logic [CNT_W-1:0] FAST_M1  = CNT_W'(FAST_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_M1   = CNT_W'(MUL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic [2:0]       ctrl_q, ctrl_d;
  rsp_t             rsp_q, rsp_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      op_count_q, op_count_d;

  logic [2:0]       dec_ctrl;
  logic             dec_legal;

  always_comb begin
    dec_ctrl  = 3'b000;
    dec_legal = 1'b1;
    case (bus.in_funct)
      6'h20:   dec_ctrl = 3'b000;
      6'h22:   dec_ctrl = 3'b001;
      6'h26:   dec_ctrl = 3'b010;
      6'h2A:   dec_ctrl = 3'b011;
      6'h18:   dec_ctrl = CTRL_MUL;
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    rsp_d       = rsp_q;
    out_valid_d = out_valid_q;
    op_count_d  = op_count_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        if (dec_legal) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          ctrl_d  = dec_ctrl;
          cnt_d   = (dec_ctrl == CTRL_MUL) ? MUL_M1 : FAST_M1;
          state_d = SETTLE;
        end else begin
          // ALU inputs are left alone; only the result path reports the fault.
          rsp_d       = '{result: 32'd0, zero: 1'b0, overflow: 1'b0, cout: 1'b0, illegal: 1'b1};
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      SETTLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // MUL leaves the ALU's overflow/carry undefined, so mask them.
          rsp_d.result   = bus.alu_out;
          rsp_d.zero     = bus.alu_zero;
          rsp_d.overflow = (ctrl_q == CTRL_MUL) ? 1'b0 : bus.alu_overflow;
          rsp_d.cout     = (ctrl_q == CTRL_MUL) ? 1'b0 : bus.alu_cout;
          rsp_d.illegal  = 1'b0;
          out_valid_d    = 1'b1;
          state_d        = DONE;
        end
      end
      DONE: if (bus.out_ready) begin
        out_valid_d = 1'b0;
        op_count_d  = op_count_q + 16'd1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      ctrl_q      <= '0;
      rsp_q       <= '0;
      out_valid_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      rsp_q       <= rsp_d;
      out_valid_q <= out_valid_d;
      op_count_q  <= op_count_d;
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.alu_a        = a_q;
  assign bus.alu_b        = b_q;
  assign bus.alu_ctrl     = ctrl_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = rsp_q.result;
  assign bus.out_zero     = rsp_q.zero;
  assign bus.out_overflow = rsp_q.overflow;
  assign bus.out_cout     = rsp_q.cout;
  assign bus.out_illegal  = rsp_q.illegal;
  assign bus.op_count     = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural stand-in for the ALU.
module tb_alu_issue_ctrl;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl #(.FAST_CYCLES(4), .MUL_CYCLES(20), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; MUL drives junk overflow/carry so the masking is visible.
  logic [32:0] sum33, dif33;
  logic [31:0] alu_res;
  always_comb begin
    sum33   = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
    dif33   = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
    alu_res = 32'd0;
    bus.alu_overflow = 1'b0;
    bus.alu_cout     = 1'b0;
    case (bus.alu_ctrl)
      3'b000: begin
        alu_res = sum33[31:0];
        bus.alu_cout = sum33[32];
        bus.alu_overflow = (bus.alu_a[31] == bus.alu_b[31]) && (alu_res[31] != bus.alu_a[31]);
      end
      3'b001: begin
        alu_res = dif33[31:0];
        bus.alu_cout = dif33[32];
        bus.alu_overflow = (bus.alu_a[31] != bus.alu_b[31]) && (alu_res[31] != bus.alu_a[31]);
      end
      3'b010: alu_res = bus.alu_a ^ bus.alu_b;
      3'b011: alu_res = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      3'b100: begin
        alu_res = bus.alu_a * bus.alu_b;
        bus.alu_overflow = 1'b1;
        bus.alu_cout = 1'b1;
      end
      default: alu_res = 32'd0;
    endcase
    bus.alu_out  = alu_res;
    bus.alu_zero = (alu_res == 32'd0);
  end

  // Presents one request, then counts edges after acceptance until out_valid.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit stable);
    logic [31:0] a0, b0;
    logic [2:0]  c0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_funct = f;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    a0 = bus.alu_a; b0 = bus.alu_b; c0 = bus.alu_ctrl;
    stable = 1'b1;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.alu_a !== a0 || bus.alu_b !== b0 || bus.alu_ctrl !== c0) stable = 1'b0;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.op_count !== 16'd0) begin errors++; $display("FAIL reset_op_count got %0d exp 0", bus.op_count); end
    checks++; if (bus.alu_ctrl !== 3'b000) begin errors++; $display("FAIL reset_alu_ctrl got %b exp 000", bus.alu_ctrl); end
    checks++; if (bus.out_result !== 32'd0) begin errors++; $display("FAIL reset_out_result got %h exp 0", bus.out_result); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int lat; bit st;
    issue(6'h20, 32'd2, 32'd5, lat, st);
    checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency got %0d exp 4", lat); end
    checks++; if (bus.out_result !== 32'd7) begin errors++; $display("FAIL add_result got %h exp 7", bus.out_result); end
    checks++; if (bus.out_zero !== 1'b0) begin errors++; $display("FAIL add_zero got %b exp 0", bus.out_zero); end
    checks++; if (bus.out_illegal !== 1'b0) begin errors++; $display("FAIL add_illegal got %b exp 0", bus.out_illegal); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL add_in_ready_done got %b exp 0", bus.in_ready); end
    handshake();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_valid_drop got %b exp 0", bus.out_valid); end
    checks++; if (bus.op_count !== 16'd1) begin errors++; $display("FAIL add_op_count got %0d exp 1", bus.op_count); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready_idle got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_sub_slt();
    int lat; bit st;
    issue(6'h22, 32'd10, 32'd10, lat, st);
    checks++; if (bus.out_result !== 32'd0) begin errors++; $display("FAIL sub_result got %h exp 0", bus.out_result); end
    checks++; if (bus.out_zero !== 1'b1) begin errors++; $display("FAIL sub_zero got %b exp 1", bus.out_zero); end
    checks++; if (bus.alu_ctrl !== 3'b001) begin errors++; $display("FAIL sub_ctrl got %b exp 001", bus.alu_ctrl); end
    handshake();
    issue(6'h2A, 32'd2, 32'd9, lat, st);
    checks++; if (lat !== 4) begin errors++; $display("FAIL slt_latency got %0d exp 4", lat); end
    checks++; if (bus.out_result !== 32'd1) begin errors++; $display("FAIL slt_result got %h exp 1", bus.out_result); end
    handshake();
    checks++; if (bus.op_count !== 16'd3) begin errors++; $display("FAIL slt_op_count got %0d exp 3", bus.op_count); end
  endtask

  task automatic test_mul();
    int lat; bit st;
    issue(6'h18, 32'd6, 32'hFFFF_FFFD, lat, st);
    checks++; if (lat !== 20) begin errors++; $display("FAIL mul_latency got %0d exp 20", lat); end
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL mul_operands_stable got %b exp 1", st); end
    checks++; if (bus.alu_ctrl !== 3'b100) begin errors++; $display("FAIL mul_ctrl got %b exp 100", bus.alu_ctrl); end
    checks++; if (bus.out_result !== 32'hFFFF_FFEE) begin errors++; $display("FAIL mul_result got %h exp ffffffee", bus.out_result); end
    checks++; if (bus.out_overflow !== 1'b0) begin errors++; $display("FAIL mul_overflow got %b exp 0", bus.out_overflow); end
    checks++; if (bus.out_cout !== 1'b0) begin errors++; $display("FAIL mul_cout got %b exp 0", bus.out_cout); end
    handshake();
    checks++; if (bus.op_count !== 16'd4) begin errors++; $display("FAIL mul_op_count got %0d exp 4", bus.op_count); end
  endtask

  task automatic test_illegal();
    int lat; bit st;
    issue(6'h21, 32'd111, 32'd222, lat, st);
    checks++; if (lat !== 0) begin errors++; $display("FAIL ill_latency got %0d exp 0", lat); end
    checks++; if (bus.out_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got %b exp 1", bus.out_illegal); end
    checks++; if (bus.out_result !== 32'd0) begin errors++; $display("FAIL ill_result got %h exp 0", bus.out_result); end
    checks++; if (bus.alu_a !== 32'd6) begin errors++; $display("FAIL ill_alu_a got %h exp 6", bus.alu_a); end
    checks++; if (bus.alu_b !== 32'hFFFF_FFFD) begin errors++; $display("FAIL ill_alu_b got %h exp fffffffd", bus.alu_b); end
    checks++; if (bus.alu_ctrl !== 3'b100) begin errors++; $display("FAIL ill_alu_ctrl got %b exp 100", bus.alu_ctrl); end
    handshake();
    checks++; if (bus.op_count !== 16'd5) begin errors++; $display("FAIL ill_op_count got %0d exp 5", bus.op_count); end
  endtask

  task automatic test_backpressure();
    int lat; bit st;
    issue(6'h20, 32'd2000000000, 32'd2000000000, lat, st);
    checks++; if (lat !== 4) begin errors++; $display("FAIL bp_latency got %0d exp 4", lat); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", i, bus.out_valid); end
      checks++; if (bus.out_result !== 32'hEE6B_2800) begin errors++; $display("FAIL bp_result[%0d] got %h exp ee6b2800", i, bus.out_result); end
      checks++; if (bus.out_overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow[%0d] got %b exp 1", i, bus.out_overflow); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, bus.in_ready); end
    end
    handshake();
    checks++; if (bus.op_count !== 16'd6) begin errors++; $display("FAIL bp_op_count got %0d exp 6", bus.op_count); end
  endtask

  task automatic test_reset_mid();
    int lat; bit st;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_funct = 6'h18;
    bus.in_a = 32'd3;
    bus.in_b = 32'd4;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.op_count !== 16'd0) begin errors++; $display("FAIL rstmid_op_count got %0d exp 0", bus.op_count); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_aborted got %b exp 0", bus.out_valid); end
    issue(6'h26, 32'hF0F0_F0F0, 32'hFF00_FF00, lat, st);
    checks++; if (bus.out_result !== 32'h0FF0_0FF0) begin errors++; $display("FAIL xor_result got %h exp 0ff00ff0", bus.out_result); end
    handshake();
    checks++; if (bus.op_count !== 16'd1) begin errors++; $display("FAIL rstmid_recount got %0d exp 1", bus.op_count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.in_valid  = 1'b0;
    bus.in_funct  = 6'h00;
    bus.in_a      = 32'd0;
    bus.in_b      = 32'd0;
    bus.out_ready = 1'b0;
    test_reset();
    test_add();
    test_sub_slt();
    test_mul();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
